// File: rtl/led_axil_wr_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite write arbiter.
// Used by led_arb_rr2 and led_axil_wr_arbiter.
package led_axil_wr_arbiter_pkg;

  // Write sequencer states: one write outstanding at a time.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // AXI response codes.
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Fixed write-channel side-band values.
  localparam logic [3:0] WSTRB_ALL  = 4'hF;
  localparam logic [2:0] AWPROT_DEF = 3'b000;

  // Convert a requester index into its one-hot strobe.
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    logic [1:0] oh;
    if (idx) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/led_arb_rr2.sv
// Two-way grant selector with an internal last-grant pointer.
// Build option: LED_ARB_FIXED_PRIO_EN -- requester 0 always wins contention
// and no pointer is built; otherwise round-robin on the last grant.
module led_arb_rr2
  import led_axil_wr_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

`ifdef LED_ARB_FIXED_PRIO_EN

  // Fixed priority: requester 0 first, requester 1 only when 0 is idle.
  always_comb begin
    gnt = 2'b00;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end else begin
      gnt = 2'b00;
    end
  end

`else

  logic last_q;
  logic last_d;

  // Round-robin pick: on contention favour the requester not served last.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer moves only when a grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (advance && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register; reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

`endif

endmodule

// File: rtl/led_axil_wr_arbiter.sv
// Two-requester AXI4-Lite write master: grants one requester, runs the
// AW/W/B handshakes, then pulses req_done/req_resp back to the winner.
// Build option: LED_ARB_FIXED_PRIO_EN selects fixed priority (see led_arb_rr2).
module led_axil_wr_arbiter
  import led_axil_wr_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [1:0]          req_valid,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          req_done,
  output logic [1:0]          req_resp,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [3:0]          m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        resp_q, resp_d;

  logic [1:0]        arb_req_s;
  logic [1:0]        gnt_s;
  logic              aw_hs_s;
  logic              w_hs_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;

  // Requests are only offered to the arbiter when idle and out of reset,
  // so req_ready stays low while ARESETN is held.
  assign arb_req_s = ((state_q == ST_IDLE) && ARESETN) ? req_valid : 2'b00;

  led_arb_rr2 u_arb (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .req     (arb_req_s),
    .advance (|arb_req_s),
    .gnt     (gnt_s)
  );

  assign aw_hs_s    = awvalid_q & m_axi_awready;
  assign w_hs_s     = wvalid_q & m_axi_wready;
  assign sel_addr_s = gnt_s[1] ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
  assign sel_data_s = gnt_s[1] ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  // Next-state and datapath decisions for the write sequencer.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    done_d    = 2'b00;
    resp_d    = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_s != 2'b00) begin
          state_d   = ST_ADDR;
          owner_d   = gnt_s[1];
          awaddr_d  = sel_addr_s;
          wdata_d   = sel_data_s;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (aw_hs_s) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end else begin
          awvalid_d = awvalid_q;
          aw_done_d = aw_done_q;
        end
        if (w_hs_s) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end else begin
          wvalid_d = wvalid_q;
          w_done_d = w_done_q;
        end
        if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_RESP: begin
        if (m_axi_bvalid) begin
          done_d  = idx_to_onehot(owner_q);
          resp_d  = m_axi_bresp;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured request, channel valids, handshake flags and completion pulse.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      owner_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      done_q    <= 2'b00;
      resp_q    <= 2'b00;
    end else begin
      owner_q   <= owner_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      done_q    <= done_d;
      resp_q    <= resp_d;
    end
  end

  assign req_ready     = gnt_s;
  assign req_done      = done_q;
  assign req_resp      = resp_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = AWPROT_DEF;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = WSTRB_ALL;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == ST_RESP);

endmodule

// File: tb/tb_led_axil_wr_arbiter.sv
// Self-checking bench for led_axil_wr_arbiter: directed vector table,
// hand-written multi-cycle sequences, and a randomized run against a
// transaction-level reference model.
module tb_led_axil_wr_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [63:0] req_addr = 64'h0;
  logic [63:0] req_wdata = 64'h0;
  logic [1:0]  req_ready, req_done, req_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready;
  logic        m_axi_awready = 1'b0;
  logic        m_axi_wready = 1'b0;
  logic        m_axi_bvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;

  int checks = 0;
  int failures = 0;

  led_axil_wr_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .req_done      (req_done),
    .req_resp      (req_resp),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1:0]  rv;
    logic        ar;
    logic        wr;
    logic        bv;
    logic [1:0]  br;
    logic [1:0]  e_rdy;
    logic        e_awv;
    logic        e_wv;
    logic        e_bry;
    logic [1:0]  e_done;
    logic [1:0]  e_resp;
    logic [31:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rv, input logic ar, input logic wr,
                       input logic bv, input logic [1:0] br);
    req_valid     = rv;
    m_axi_awready = ar;
    m_axi_wready  = wr;
    m_axi_bvalid  = bv;
    m_axi_bresp   = br;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  // Expected winner for a set of valid bits given the last-granted index.
  function automatic logic pick(input logic [1:0] rv, input logic last);
    logic p;
    if (rv == 2'b11) begin
`ifdef LED_ARB_FIXED_PRIO_EN
      p = 1'b0;
`else
      p = ~last;
`endif
    end else begin
      p = rv[1];
    end
    return p;
  endfunction

  // Reference model state: a transaction is either absent, waiting on its
  // address/data acceptances, or waiting on its response.
  logic       m_busy, m_aw, m_w, m_owner, m_last, m_done, m_done_owner;
  logic [1:0] m_resp;
  logic [31:0] m_addr, m_data;

  // Watchdog so a stuck run still terminates.
  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         grants [4];
    int         ng;
    logic       p;
    logic       any;
    logic [1:0] e_rdy, e_done;
    logic       e_awv, e_wv, e_bry;

    tbl[0] = '{2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0};
    tbl[1] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0101FFFF};
    tbl[2] = '{2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0};
    tbl[3] = '{2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 32'h0, 32'h0};
    tbl[4] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 32'hC, 32'hbeef0011};
    tbl[5] = '{2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0};
    tbl[6] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 32'h0, 32'h0};
    tbl[7] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0};

    // Reset values with requests pending.
    ARESETN = 1'b0;
    drive(2'b11, 1'b1, 1'b1, 1'b1, 2'b11);
    req_addr  = {32'h0000000C, 32'h00000000};
    req_wdata = {32'hbeef0011, 32'h0101FFFF};
    @(negedge ACLK); @(negedge ACLK); #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_ctl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, req_done, req_resp}, 7'd0);
    chk("rst_addr_data", {m_axi_awaddr, m_axi_wdata}, 64'h0);
    chk("const_prot_strb", {m_axi_awprot, m_axi_wstrb}, {3'b000, 4'hF});

    // Directed table: zero-wait write from req0, then SLVERR write from req1.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge ACLK);
      drive(tbl[i].rv, tbl[i].ar, tbl[i].wr, tbl[i].bv, tbl[i].br);
      #1;
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_valids", i), {m_axi_awvalid, m_axi_wvalid, m_axi_bready},
          {tbl[i].e_awv, tbl[i].e_wv, tbl[i].e_bry});
      chk($sformatf("tbl%0d_done", i), req_done, tbl[i].e_done);
      if (tbl[i].e_awv) chk($sformatf("tbl%0d_awaddr", i), m_axi_awaddr, tbl[i].e_addr);
      if (tbl[i].e_wv)  chk($sformatf("tbl%0d_wdata", i), m_axi_wdata, tbl[i].e_data);
      if (tbl[i].e_done != 2'b00) chk($sformatf("tbl%0d_resp", i), req_resp, tbl[i].e_resp);
    end

    // Contention with a zero-wait slave: grants alternate (fixed: req0 only).
    do_reset();
    req_addr  = {32'h00000008, 32'h00000004};
    req_wdata = {32'hdead0011, 32'habcd0001};
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge ACLK);
      drive(2'b11, 1'b1, 1'b1, 1'b1, 2'b00);
      #1;
      if (req_ready != 2'b00) begin
        grants[ng] = int'(req_ready);
        ng++;
      end
    end
    chk("rr_grant_count", ng, 4);
    for (int g = 0; g < ng; g++) begin
`ifdef LED_ARB_FIXED_PRIO_EN
      chk($sformatf("rr_grant%0d", g), grants[g], 1);
`else
      chk($sformatf("rr_grant%0d", g), grants[g], (g % 2 == 0) ? 1 : 2);
`endif
    end

    // W accepted two cycles before AW: awaddr holds while awvalid waits.
    do_reset();
    req_addr  = {32'h00000008, 32'h00000004};
    req_wdata = {32'hdead0011, 32'habcd0001};
    @(negedge ACLK); drive(2'b10, 1'b0, 1'b0, 1'b0, 2'b00); #1;
    chk("skew_ready", req_ready, 2'b10);
    @(negedge ACLK); drive(2'b00, 1'b0, 1'b1, 1'b0, 2'b00);
    req_addr = {32'hFFFFFFF0, 32'hFFFFFFF0}; #1;
    chk("skew_c1_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    chk("skew_c1_addr", m_axi_awaddr, 32'h8);
    @(negedge ACLK); drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00); #1;
    chk("skew_c2_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
    chk("skew_c2_addr", m_axi_awaddr, 32'h8);
    @(negedge ACLK); drive(2'b00, 1'b1, 1'b0, 1'b0, 2'b00); #1;
    chk("skew_c3_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b100);
    chk("skew_c3_addr", m_axi_awaddr, 32'h8);
    @(negedge ACLK); drive(2'b00, 1'b0, 1'b0, 1'b1, 2'b00); #1;
    chk("skew_c4_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
    @(negedge ACLK); drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00); #1;
    chk("skew_done", {req_done, req_resp}, {2'b10, 2'b00});
    @(negedge ACLK); #1;
    chk("skew_single_done", req_done, 2'b00);

    // Reset while waiting for B: everything drops, no done, req0 wins next.
    do_reset();
    req_addr  = {32'h00000008, 32'h00000004};
    @(negedge ACLK); drive(2'b01, 1'b1, 1'b1, 1'b0, 2'b00); #1;
    chk("rstmid_ready", req_ready, 2'b01);
    @(negedge ACLK); drive(2'b00, 1'b1, 1'b1, 1'b0, 2'b00);
    @(negedge ACLK); drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00); #1;
    chk("rstmid_in_resp", m_axi_bready, 1'b1);
    #1;
    ARESETN = 1'b0;
    m_axi_bvalid = 1'b1;
    #1;
    chk("rstmid_drop", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, req_ready, req_done}, 7'd0);
    @(negedge ACLK); #1;
    chk("rstmid_no_done", req_done, 2'b00);
    @(negedge ACLK);
    ARESETN = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00); #1;
    chk("rstmid_after_done", req_done, 2'b00);
    @(negedge ACLK); drive(2'b11, 1'b0, 1'b0, 1'b0, 2'b00); #1;
    chk("rstmid_contention", req_ready, 2'b01);

    // Randomized run against the transaction-level model.
    do_reset();
    m_busy = 1'b0; m_aw = 1'b0; m_w = 1'b0; m_owner = 1'b0; m_last = 1'b1;
    m_done = 1'b0; m_done_owner = 1'b0; m_resp = 2'b00; m_addr = 32'h0; m_data = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge ACLK);
      req_valid     = 2'($urandom_range(0, 3));
      req_addr      = {$urandom, $urandom};
      req_wdata     = {$urandom, $urandom};
      m_axi_awready = 1'($urandom_range(0, 1));
      m_axi_wready  = 1'($urandom_range(0, 1));
      m_axi_bvalid  = (m_busy && !m_aw && !m_w) ? 1'($urandom_range(0, 1)) : 1'b0;
      m_axi_bresp   = 2'($urandom_range(0, 3));
      #1;
      any   = |req_valid;
      p     = pick(req_valid, m_last);
      e_rdy = (!m_busy && any) ? (p ? 2'b10 : 2'b01) : 2'b00;
      e_awv = m_busy && m_aw;
      e_wv  = m_busy && m_w;
      e_bry = m_busy && !m_aw && !m_w;
      e_done = m_done ? (m_done_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("rnd_ctl", {req_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, req_done},
          {e_rdy, e_awv, e_wv, e_bry, e_done});
      if (e_awv) chk("rnd_awaddr", m_axi_awaddr, m_addr);
      if (e_wv)  chk("rnd_wdata", m_axi_wdata, m_data);
      if (m_done) chk("rnd_resp", req_resp, m_resp);
      // Advance the model by one clock.
      m_done = 1'b0;
      if (!m_busy) begin
        if (any) begin
          m_busy  = 1'b1;
          m_aw    = 1'b1;
          m_w     = 1'b1;
          m_owner = p;
          m_last  = p;
          m_addr  = p ? req_addr[63:32] : req_addr[31:0];
          m_data  = p ? req_wdata[63:32] : req_wdata[31:0];
        end
      end else if (m_aw || m_w) begin
        if (m_aw && m_axi_awready) m_aw = 1'b0;
        if (m_w && m_axi_wready)   m_w = 1'b0;
      end else if (m_axi_bvalid) begin
        m_done       = 1'b1;
        m_done_owner = m_owner;
        m_resp       = m_axi_bresp;
        m_busy       = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
